// File: rtl/exe_stage.sv
// Execute stage: ALU, beq/j resolution and an iterative shift-add multiplier feeding EX/MEM.
// Define EXE_FORWARD_EN to add MEM/WB operand forwarding ports.
module exe_stage #(
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [163:0] id_ex,
`ifdef EXE_FORWARD_EN
  input  logic         mem_we,
  input  logic [4:0]   mem_reg,
  input  logic [31:0]  mem_data,
  input  logic         wb_we,
  input  logic [4:0]   wb_reg,
  input  logic [31:0]  wb_data,
`endif
  output logic         stall,
  output logic         redirect,
  output logic [31:0]  target,
  output logic [72:0]  ex_mem
);

  localparam int MUL_CYCLES = 32 / MUL_STEP;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MUL_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic        reg_write, mem_to_reg, mem_write, branch_eq, jump;
  logic        alu_src, reg_dst, load_ctrl;
  logic [2:0]  alu_c;
  logic [4:0]  rt, rd, rs, wreg;
  logic [15:0] imm;
  logic [31:0] qa, qb, pc4, imm_sext;
  logic [25:0] adr;

  assign reg_write  = id_ex[0];
  assign mem_to_reg = id_ex[1];
  assign mem_write  = id_ex[2];
  assign branch_eq  = id_ex[3];
  assign jump       = id_ex[4];
  assign alu_src    = id_ex[5];
  assign reg_dst    = id_ex[6];
  assign alu_c      = id_ex[9:7];
  assign rt         = id_ex[14:10];
  assign rd         = id_ex[19:15];
  assign imm        = id_ex[35:20];
  assign qa         = id_ex[67:36];
  assign qb         = id_ex[99:68];
  assign pc4        = id_ex[131:100];
  assign adr        = id_ex[157:132];
  assign rs         = id_ex[162:158];
  assign load_ctrl  = id_ex[163];

  assign imm_sext = {{16{imm[15]}}, imm};
  assign wreg     = reg_dst ? rd : rt;

  logic [31:0] fwd_a, fwd_b;

`ifdef EXE_FORWARD_EN
  // MEM is the younger producer, so it wins over WB; r0 is hardwired zero.
  always_comb begin
    fwd_a = qa;
    fwd_b = qb;
    if (mem_we && (mem_reg != 5'd0) && (mem_reg == rs)) begin
      fwd_a = mem_data;
    end else if (wb_we && (wb_reg != 5'd0) && (wb_reg == rs)) begin
      fwd_a = wb_data;
    end
    if (mem_we && (mem_reg != 5'd0) && (mem_reg == rt)) begin
      fwd_b = mem_data;
    end else if (wb_we && (wb_reg != 5'd0) && (wb_reg == rt)) begin
      fwd_b = wb_data;
    end
  end
`else
  assign fwd_a = qa;
  assign fwd_b = qb;
`endif

  logic [31:0] alu_b, alu_result;

  assign alu_b = alu_src ? imm_sext : fwd_b;

  always_comb begin
    alu_result = 32'd0;
    case (alu_c)
      3'b000:  alu_result = fwd_a + alu_b;
      3'b001:  alu_result = fwd_a - alu_b;
      3'b010:  alu_result = fwd_a & alu_b;
      3'b011:  alu_result = fwd_a | alu_b;
      3'b100:  alu_result = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      3'b101:  alu_result = fwd_a ^ alu_b;
      3'b110:  alu_result = {imm, 16'd0};
      default: alu_result = 32'd0;  // mul goes through the FSM
    endcase
  end

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      acc_reg, acc_next, acc_sum;
  logic [31:0]      mcand_reg, mcand_next;
  logic [31:0]      mplier_reg, mplier_next;
  logic [3:0]       ctl_reg, ctl_next;
  logic [4:0]       wreg_reg, wreg_next;
  logic [31:0]      sdata_reg, sdata_next;
  logic [72:0]      ex_mem_reg, ex_mem_next;
  logic             mul_start;

  assign mul_start = (state_reg == S_IDLE) && (alu_c == 3'b111) && reg_write;

  // One partial product per retired multiplier bit.
  logic [31:0] pp [MUL_STEP];

  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 32'd0;
  end

  always_comb begin
    acc_sum = acc_reg;
    for (int k = 0; k < MUL_STEP; k++) begin
      acc_sum = acc_sum + pp[k];
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    ctl_next    = ctl_reg;
    wreg_next   = wreg_reg;
    sdata_next  = sdata_reg;
    ex_mem_next = 73'd0;
    case (state_reg)
      S_IDLE: begin
        if (mul_start) begin
          state_next  = S_BUSY;
          count_next  = '0;
          acc_next    = 32'd0;
          mcand_next  = fwd_a;
          mplier_next = alu_b;
          ctl_next    = {load_ctrl, mem_write, mem_to_reg, reg_write};
          wreg_next   = wreg;
          sdata_next  = fwd_b;
        end else begin
          ex_mem_next = {fwd_b, alu_result, wreg, load_ctrl, mem_write, mem_to_reg, reg_write};
        end
      end
      S_BUSY: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << MUL_STEP;
        mplier_next = mplier_reg >> MUL_STEP;
        count_next  = count_reg + 6'd1;
        if (count_reg == LAST_COUNT) begin
          state_next  = S_IDLE;
          count_next  = '0;
          ex_mem_next = {sdata_reg, acc_sum, wreg_reg, ctl_reg};
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      acc_reg    <= 32'd0;
      mcand_reg  <= 32'd0;
      mplier_reg <= 32'd0;
      ctl_reg    <= 4'd0;
      wreg_reg   <= 5'd0;
      sdata_reg  <= 32'd0;
      ex_mem_reg <= 73'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      ctl_reg    <= ctl_next;
      wreg_reg   <= wreg_next;
      sdata_reg  <= sdata_next;
      ex_mem_reg <= ex_mem_next;
    end
  end

  assign ex_mem = ex_mem_reg;
  assign stall  = clr && ((state_reg == S_BUSY) || mul_start);

  // Branches resolve only when this stage actually owns the instruction.
  always_comb begin
    redirect = 1'b0;
    target   = 32'd0;
    if (clr && (state_reg == S_IDLE) && !mul_start) begin
      if (jump) begin
        redirect = 1'b1;
        target   = {pc4[31:28], adr, 2'b00};
      end else if (branch_eq && (fwd_a == fwd_b)) begin
        redirect = 1'b1;
        target   = pc4 + {imm_sext[29:0], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against a plain-arithmetic reference model.
module tb_exe_stage;

  localparam int MUL_STEP   = 1;
  localparam int MUL_CYCLES = 32 / MUL_STEP;

  logic         clk = 1'b0;
  logic         clr;
  logic [163:0] id_ex;
  logic         stall;
  logic         redirect;
  logic [31:0]  target;
  logic [72:0]  ex_mem;
`ifdef EXE_FORWARD_EN
  logic         mem_we   = 1'b0;
  logic [4:0]   mem_reg  = 5'd0;
  logic [31:0]  mem_data = 32'd0;
  logic         wb_we    = 1'b0;
  logic [4:0]   wb_reg   = 5'd0;
  logic [31:0]  wb_data  = 32'd0;
`endif

  int checks = 0;
  int errors = 0;

  exe_stage #(.MUL_STEP(MUL_STEP)) dut (
    .clk      (clk),
    .clr      (clr),
    .id_ex    (id_ex),
`ifdef EXE_FORWARD_EN
    .mem_we   (mem_we),
    .mem_reg  (mem_reg),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
`endif
    .stall    (stall),
    .redirect (redirect),
    .target   (target),
    .ex_mem   (ex_mem)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [72:0] got, input logic [72:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [163:0] mk(
    input logic rw, input logic m2r, input logic mw, input logic beq, input logic jmp,
    input logic asrc, input logic rdst, input logic [2:0] aluc, input logic [4:0] rt,
    input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] qa, input logic [31:0] qb,
    input logic [31:0] pc4, input logic [25:0] adr, input logic [4:0] rs, input logic lc);
    logic [163:0] ie;
    ie = '0;
    ie[0] = rw; ie[1] = m2r; ie[2] = mw; ie[3] = beq; ie[4] = jmp; ie[5] = asrc; ie[6] = rdst;
    ie[9:7] = aluc; ie[14:10] = rt; ie[19:15] = rd; ie[35:20] = imm;
    ie[67:36] = qa; ie[99:68] = qb; ie[131:100] = pc4; ie[157:132] = adr;
    ie[162:158] = rs; ie[163] = lc;
    return ie;
  endfunction

  // Reference: what the memory stage should receive for one instruction.
  function automatic logic [72:0] ref_ex_mem(input logic [163:0] ie);
    logic [31:0] a, b, r, sx;
    logic [15:0] imm;
    logic [4:0]  wr;
    imm = ie[35:20];
    sx  = {{16{imm[15]}}, imm};
    a   = ie[67:36];
    b   = ie[5] ? sx : ie[99:68];
    case (ie[9:7])
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      3'd5: r = a ^ b;
      3'd6: r = {imm, 16'h0000};
      default: r = ie[0] ? 32'(a * b) : 32'd0;
    endcase
    wr = ie[6] ? ie[19:15] : ie[14:10];
    return {ie[99:68], r, wr, ie[163], ie[2], ie[1], ie[0]};
  endfunction

  function automatic logic [32:0] ref_branch(input logic [163:0] ie);
    logic [31:0] pc4, off;
    pc4 = ie[131:100];
    off = 32'($signed(ie[35:20])) * 32'd4;
    if (ie[4]) return {1'b1, pc4[31:28], ie[157:132], 2'b00};
    if (ie[3] && (ie[67:36] == ie[99:68])) return {1'b1, pc4 + off};
    return 33'd0;
  endfunction

  function automatic logic [163:0] rand_ie(input bit want_mul);
    logic [2:0]  aluc;
    logic        rw, beq;
    logic [31:0] qa, qb;
    aluc = 3'($urandom_range(0, 7));
    rw   = 1'($urandom);
    if (want_mul) begin
      aluc = 3'b111;
      rw   = 1'b1;
    end else if (aluc == 3'b111) begin
      rw = 1'b0;
    end
    beq = ($urandom_range(0, 4) == 0);
    qa  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
    qb  = (beq && $urandom_range(0, 1) == 1) ? qa : 32'($urandom);
    return mk(rw, 1'($urandom), 1'($urandom), beq, ($urandom_range(0, 9) == 0),
              1'($urandom), 1'($urandom), aluc, 5'($urandom), 5'($urandom), 16'($urandom),
              qa, qb, 32'($urandom), 26'($urandom), 5'($urandom), 1'($urandom));
  endfunction

  task automatic do_single(input logic [163:0] ie, input string nm,
                           output logic r_o, output logic [31:0] t_o);
    logic [32:0] br;
    @(negedge clk);
    id_ex = ie;
    #1;
    br = ref_branch(ie);
    r_o = redirect;
    t_o = target;
    check_val({nm, "_stall"}, stall, 1'b0);
    check_val({nm, "_redirect"}, redirect, br[32]);
    check_val({nm, "_target"}, target, br[31:0]);
    @(posedge clk);
    #1;
    check_val({nm, "_ex_mem"}, ex_mem, ref_ex_mem(ie));
    $display("TXN %0s aluc=%0d redirect=%0b target=%h ex_mem=%h", nm, ie[9:7], r_o, t_o, ex_mem);
  endtask

  task automatic do_mul(input logic [163:0] ie, input logic [163:0] nxt, input string nm);
    @(negedge clk);
    id_ex = ie;
    for (int i = 0; i <= MUL_CYCLES; i++) begin
      #1;
      check_val({nm, "_stall"}, stall, 1'b1);
      check_val({nm, "_redirect"}, redirect, 1'b0);
      @(posedge clk);
      #1;
      if (i < MUL_CYCLES) check_val({nm, "_bubble"}, ex_mem, 73'd0);
      else                check_val({nm, "_product"}, ex_mem, ref_ex_mem(ie));
      if (i == 0) id_ex = nxt;
    end
    $display("TXN %0s mul a=%h b=%h ex_mem=%h", nm, ie[67:36], ie[99:68], ex_mem);
  endtask

  logic [163:0] ie_a, ie_b;
  logic         r_got;
  logic [31:0]  t_got;

  initial begin
    clr   = 1'b0;
    id_ex = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ex_mem", ex_mem, 73'd0);
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_redirect", redirect, 1'b0);
    @(negedge clk);
    clr = 1'b1;

    ie_a = mk(1,0,0,0,0,0,1,3'd0,5'd9,5'd3,16'h0,32'd7,32'hFFFFFFFE,32'h0,26'h0,5'd1,0);
    do_single(ie_a, "add", r_got, t_got);
    check_val("add_res", ex_mem[40:9], 32'd5);
    check_val("add_wreg", ex_mem[8:4], 5'd3);
    check_val("add_rw", ex_mem[0], 1'b1);

    ie_a = mk(1,0,0,0,0,1,0,3'd6,5'd4,5'd0,16'h8001,32'd0,32'd0,32'h0,26'h0,5'd0,0);
    do_single(ie_a, "lui", r_got, t_got);
    check_val("lui_res", ex_mem[40:9], 32'h80010000);

    ie_a = mk(1,0,0,0,0,0,0,3'd4,5'd4,5'd0,16'h0,32'hFFFFFFFF,32'd1,32'h0,26'h0,5'd0,0);
    do_single(ie_a, "slt", r_got, t_got);
    check_val("slt_res", ex_mem[40:9], 32'd1);

    ie_a = mk(0,0,0,1,0,0,0,3'd1,5'd4,5'd0,16'hFFFE,32'd9,32'd9,32'h100,26'h0,5'd0,0);
    do_single(ie_a, "beq", r_got, t_got);
    check_val("beq_redirect", r_got, 1'b1);
    check_val("beq_target", t_got, 32'hF8);

    ie_a = mk(0,0,0,0,1,0,0,3'd0,5'd0,5'd0,16'h0,32'd1,32'd2,32'h10000004,26'h40,5'd0,0);
    do_single(ie_a, "jump", r_got, t_got);
    check_val("jump_target", t_got, 32'h10000100);

    do_single('0, "bubble", r_got, t_got);
    check_val("bubble_ex_mem", ex_mem, 73'd0);

    ie_a = mk(0,0,0,0,0,0,1,3'd7,5'd0,5'd6,16'h0,32'd5,32'd6,32'h0,26'h0,5'd0,0);
    do_single(ie_a, "mulnorw", r_got, t_got);
    check_val("mulnorw_res", ex_mem[40:9], 32'd0);

    ie_a = mk(1,0,0,0,0,0,1,3'd7,5'd0,5'd8,16'h0,32'h12345,32'h10,32'h0,26'h0,5'd0,0);
    ie_b = mk(1,0,0,0,0,0,1,3'd0,5'd0,5'd9,16'h0,32'd1,32'd1,32'h0,26'h0,5'd0,0);
    do_mul(ie_a, ie_b, "mul");
    check_val("mul_res", ex_mem[40:9], 32'h123450);
    do_single(ie_b, "after_mul", r_got, t_got);
    check_val("after_mul_res", ex_mem[40:9], 32'd2);

    ie_b = mk(0,0,0,1,0,0,0,3'd1,5'd0,5'd0,16'h0004,32'd3,32'd3,32'h200,26'h0,5'd0,0);
    do_mul(ie_a, ie_b, "mul_br");
    do_single(ie_b, "br_after_mul", r_got, t_got);
    check_val("br_after_mul_redirect", r_got, 1'b1);

    // Reset arriving mid-multiply, at count 5.
    @(negedge clk);
    id_ex = ie_a;
    @(posedge clk);
    #1;
    id_ex = mk(1,0,0,0,0,0,1,3'd0,5'd0,5'd2,16'h0,32'd20,32'd22,32'h0,26'h0,5'd0,0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_val("midrst_stall", stall, 1'b0);
    check_val("midrst_redirect", redirect, 1'b0);
    @(posedge clk);
    #1;
    check_val("midrst_ex_mem", ex_mem, 73'd0);
    @(negedge clk);
    clr = 1'b1;
    do_single(id_ex, "post_rst_add", r_got, t_got);
    check_val("post_rst_res", ex_mem[40:9], 32'd42);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ie_a = rand_ie(1'b1);
        ie_b = rand_ie(1'b0);
        do_mul(ie_a, ie_b, "rnd_mul");
        do_single(ie_b, "rnd_next", r_got, t_got);
      end else begin
        do_single(rand_ie(1'b0), "rnd", r_got, t_got);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its 164-bit bundle.
- Computes the ALU result, resolves beq/j redirects, and runs an iterative multi-cycle multiply with a pipeline stall.
- Registers results into a 73-bit EX/MEM bundle for the memory stage.

Parameters:
- MUL_STEP, 1, multiplier bits retired per BUSY cycle (legal: 1, 2, 4); MUL_CYCLES = 32/MUL_STEP.

Ports:
- clk  in  1  clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-low (clr==0 at posedge resets).
- id_ex  in  164  ID/EX bundle: [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] BranchEq, [4] Jump, [5] ALUSrc, [6] RegDst, [9:7] ALUc, [14:10] Rt, [19:15] Rd, [35:20] imm, [67:36] qa, [99:68] qb, [131:100] pc4, [157:132] adr, [162:158] Rs, [163] LoadCtrl.
- stall  out  1  freeze PC and IF/ID; ID/EX keeps re-capturing the frozen ID instruction.
- redirect  out  1  branch/jump taken; upstream loads PC from target and flushes IF/ID and ID/EX.
- target  out  32  redirect PC.
- ex_mem  out  73  [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] LoadCtrl, [8:4] wreg, [40:9] result, [72:41] store data.

Behaviour:
- Operand A = qa. Operand B = ALUSrc ? sign-extended imm : qb. wreg = RegDst ? Rd : Rt.
- ALUc decode, all results mod 2^32, overflow ignored:
  - 000 add; 001 sub; 010 and; 011 or.
  - 100 slt (signed, result 0/1); 101 xor.
  - 110 lui ({imm, 16'b0}).
  - 111 mul (low 32 bits of the product, signed/unsigned-agnostic).
- A mul is started when ALUc==111 && RegWrite==1. ALUc==111 with RegWrite==0 behaves as a bubble, result 0.
- FSM IDLE/BUSY:
  - IDLE, non-mul: combinational result; ex_mem loads at the posedge (1-cycle latency); stall=0.
  - IDLE, mul detected in cycle t: stall=1 in cycle t. At the posedge, latch operands, control fields and wreg; clear accumulator; count=0; go to BUSY.
  - BUSY: stall=1. Each cycle retires MUL_STEP multiplier bits, count++.
  - BUSY, ex_mem while count<MUL_CYCLES-1: loads all-zero (bubble); id_ex is ignored.
  - BUSY, final cycle (count==MUL_CYCLES-1): ex_mem loads the completed product with the latched controls; return to IDLE.
  - Net: stall is high for MUL_CYCLES+1 cycles (t..t+MUL_CYCLES); the product is visible after the posedge ending cycle t+MUL_CYCLES.
- The instruction following the mul sits in id_ex on return to IDLE and executes normally the next cycle.
- Branch/jump resolution (combinational), only in IDLE with no mul starting; otherwise redirect=0:
  - Jump=1: redirect=1, target={pc4[31:28], adr, 2'b00}.
  - Else BranchEq=1 and qa==qb: redirect=1, target=pc4 + (sext(imm)<<2).
  - Jump has priority over BranchEq.
  - redirect=0 ⇒ target=0.
  - Branch/jump instructions still pass their controls to ex_mem (normally RegWrite=0).
- Store data = qb, or the forwarded B-source when FORWARD_EN is defined.
- Reset (clr==0 at posedge), including mid-multiply:
  - state=IDLE, count=0, accumulator=0, ex_mem=0.
  - stall and redirect forced to 0 while clr==0.
- An all-zero id_ex (flushed bubble) yields ex_mem with all control bits 0.

Optional Feature:
- Macro: EXE_FORWARD_EN.
- Defined: adds ports mem_we (in 1), mem_reg (in 5), mem_data (in 32), wb_we (in 1), wb_reg (in 5), wb_data (in 32).
  - qa is replaced when Rs matches a forward source, qb when Rt matches.
  - MEM source has priority over WB.
  - Register 0 is never forwarded.
  - Forwarded values feed the ALU, branch compare, mul operand latch and store data.
- Undefined: ports absent; qa/qb used directly.

Test Plan:
- Reset: drive clr=0 during BUSY at count 5 → next cycle ex_mem=0, stall=0, redirect=0; a following add executes normally.
- add: qa=7, qb=0xFFFFFFFE, ALUc=000, RegWrite=1, RegDst=1, Rd=3 → after 1 edge ex_mem result=5, wreg=3, [0]=1.
- lui/slt: ALUSrc=1, imm=0x8001, ALUc=110 → result 0x80010000. ALUc=100, qa=-1, qb=1 → result 1.
- beq: pc4=0x100, imm=0xFFFE, qa=qb=9 → redirect=1, target=0xF8. Jump with adr=0x0000040, pc4=0x10000004 → target=0x10000100.
- mul (MUL_STEP=1): qa=0x12345, qb=0x10 enters cycle t → stall high 33 cycles; ex_mem bubbles; then result=0x123450. Next instruction (add 1+1) result 2 one cycle later.
- Branch during BUSY: id_ex holds a taken beq while mul is busy → redirect stays 0 until IDLE, then asserts.
